// File: rtl/ucdp_sfifo_ext.sv
// ucdp_sfifo_ext: single-clock FIFO with almost-full/almost-empty thresholds,
// optional registered read data, synchronous flush and sticky error flags.
//
// Ports:
//   src_clk_i, src_rst_an_i          clock, asynchronous low-active reset
//   dft_mode_*_i                     test control, no functional effect
//   flush_i                          synchronous clear of pointers and levels
//   wr_en_i, wr_data_i               write request and data
//   wr_full_o, wr_afull_o            full, level >= afull_p
//   wr_space_avail_o                 free entries
//   rd_en_i                          read request
//   rd_data_o, rd_valid_o            read data and its qualifier
//   rd_empty_o, rd_aempty_o          empty, level <= aempty_p
//   rd_data_avail_o                  stored entries
//   ovf_o, udf_o, err_clr_i          sticky overflow/underflow and their clear
module ucdp_sfifo_ext #(
    parameter int dwidth_p = 8,
    parameter int depth_p  = 4,
    parameter int awidth_p = $clog2(depth_p + 1),
    parameter int afull_p  = depth_p - 1,
    parameter int aempty_p = 1,
    parameter bit outreg_p = 1'b0
) (
    input  logic                src_clk_i,
    input  logic                src_rst_an_i,
    input  logic                dft_mode_test_mode_i,
    input  logic                dft_mode_scan_mode_i,
    input  logic                dft_mode_scan_shift_i,
    input  logic                dft_mode_mbist_mode_i,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [dwidth_p-1:0] wr_data_i,
    output logic                wr_full_o,
    output logic                wr_afull_o,
    output logic [awidth_p-1:0] wr_space_avail_o,
    input  logic                rd_en_i,
    output logic [dwidth_p-1:0] rd_data_o,
    output logic                rd_valid_o,
    output logic                rd_empty_o,
    output logic                rd_aempty_o,
    output logic [awidth_p-1:0] rd_data_avail_o,
    output logic                ovf_o,
    output logic                udf_o,
    input  logic                err_clr_i
);
    localparam int pwidth_c = $clog2(depth_p);
    localparam logic [pwidth_c-1:0] ptr_last_c = pwidth_c'(depth_p - 1);
    localparam logic [awidth_p-1:0] depth_c = awidth_p'(depth_p);
    localparam logic [awidth_p-1:0] afull_c = awidth_p'(afull_p);
    localparam logic [awidth_p-1:0] aempty_c = awidth_p'(aempty_p);

    logic [dwidth_p-1:0] mem_q [depth_p];
    logic [pwidth_c-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [awidth_p-1:0] load_q, load_d, space_q;
    logic full_q, empty_q, afull_q, aempty_q, ovf_q, ovf_d, udf_q, udf_d;
    logic wr_acc, rd_acc;
    logic unused_dft;

    assign unused_dft = &{dft_mode_test_mode_i, dft_mode_scan_mode_i,
                          dft_mode_scan_shift_i, dft_mode_mbist_mode_i};

    // A write into a full FIFO is fine when a read frees a slot in the same cycle.
    assign wr_acc = wr_en_i & (~full_q | rd_en_i) & ~flush_i;
    assign rd_acc = rd_en_i & ~empty_q & ~flush_i;

    always_comb begin
        load_d   = flush_i ? '0
                 : (wr_acc & ~rd_acc) ? load_q + 1'b1
                 : (rd_acc & ~wr_acc) ? load_q - 1'b1
                 : load_q;
        // Pointers wrap explicitly so non-power-of-2 depths work.
        wr_ptr_d = flush_i ? '0 : ~wr_acc ? wr_ptr_q
                 : (wr_ptr_q == ptr_last_c) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = flush_i ? '0 : ~rd_acc ? rd_ptr_q
                 : (rd_ptr_q == ptr_last_c) ? '0 : rd_ptr_q + 1'b1;
        // A new error event outranks a simultaneous clear.
        ovf_d    = (wr_en_i & full_q & ~rd_en_i & ~flush_i) | (ovf_q & ~err_clr_i);
        udf_d    = (rd_en_i & empty_q & ~flush_i) | (udf_q & ~err_clr_i);
    end

    always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
        if (!src_rst_an_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            load_q   <= '0;
            space_q  <= depth_c;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            load_q   <= load_d;
            space_q  <= depth_c - load_d;
            full_q   <= load_d == depth_c;
            empty_q  <= load_d == '0;
            afull_q  <= load_d >= afull_c;
            aempty_q <= load_d <= aempty_c;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge src_clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
    end

    if (outreg_p) begin : g_outreg
        logic [dwidth_p-1:0] rd_data_q;
        logic                rd_valid_q;
        always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
            if (!src_rst_an_i) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
            end
        end
        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end else begin : g_showahead
        assign rd_data_o  = mem_q[rd_ptr_q];
        assign rd_valid_o = ~empty_q;
    end

    assign wr_full_o        = full_q;
    assign wr_afull_o       = afull_q;
    assign wr_space_avail_o = space_q;
    assign rd_empty_o       = empty_q;
    assign rd_aempty_o      = aempty_q;
    assign rd_data_avail_o  = load_q;
    assign ovf_o            = ovf_q;
    assign udf_o            = udf_q;
endmodule

// File: tb/tb_ucdp_sfifo_ext.sv
// tb_ucdp_sfifo_ext: checks a depth-4 show-ahead FIFO and a depth-5 registered-output FIFO against queue models.
module tb_ucdp_sfifo_ext;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] dft = 4'h0;
    logic fl_a = 0, wr_a = 0, rd_a = 0, clr_a = 0, fl_b = 0, wr_b = 0, rd_b = 0, clr_b = 0;
    logic [7:0] wd_a = 0, wd_b = 0, rdd_a, rdd_b;
    logic full_a, afull_a, empty_a, aempty_a, valid_a, ovf_a_o, udf_a_o;
    logic full_b, afull_b, empty_b, aempty_b, valid_b, ovf_b_o, udf_b_o;
    logic [2:0] space_a, avail_a, space_b, avail_b;
    int vec = 0, miss = 0;

    logic [7:0] qa[$], qb[$];
    logic ovf_a = 0, udf_a = 0, ovf_b = 0, udf_b = 0, vb = 0;
    logic [7:0] db = 0;

    wire [12:0] stat_a = {full_a, afull_a, space_a, empty_a, aempty_a, avail_a, valid_a, ovf_a_o, udf_a_o};
    wire [12:0] stat_b = {full_b, afull_b, space_b, empty_b, aempty_b, avail_b, valid_b, ovf_b_o, udf_b_o};

    always #5 clk = ~clk;

    ucdp_sfifo_ext dut_a (
        .src_clk_i(clk), .src_rst_an_i(rst_n),
        .dft_mode_test_mode_i(dft[0]), .dft_mode_scan_mode_i(dft[1]),
        .dft_mode_scan_shift_i(dft[2]), .dft_mode_mbist_mode_i(dft[3]),
        .flush_i(fl_a), .wr_en_i(wr_a), .wr_data_i(wd_a),
        .wr_full_o(full_a), .wr_afull_o(afull_a), .wr_space_avail_o(space_a),
        .rd_en_i(rd_a), .rd_data_o(rdd_a), .rd_valid_o(valid_a),
        .rd_empty_o(empty_a), .rd_aempty_o(aempty_a), .rd_data_avail_o(avail_a),
        .ovf_o(ovf_a_o), .udf_o(udf_a_o), .err_clr_i(clr_a)
    );

    ucdp_sfifo_ext #(.depth_p(5), .outreg_p(1'b1)) dut_b (
        .src_clk_i(clk), .src_rst_an_i(rst_n),
        .dft_mode_test_mode_i(dft[0]), .dft_mode_scan_mode_i(dft[1]),
        .dft_mode_scan_shift_i(dft[2]), .dft_mode_mbist_mode_i(dft[3]),
        .flush_i(fl_b), .wr_en_i(wr_b), .wr_data_i(wd_b),
        .wr_full_o(full_b), .wr_afull_o(afull_b), .wr_space_avail_o(space_b),
        .rd_en_i(rd_b), .rd_data_o(rdd_b), .rd_valid_o(valid_b),
        .rd_empty_o(empty_b), .rd_aempty_o(aempty_b), .rd_data_avail_o(avail_b),
        .ovf_o(ovf_b_o), .udf_o(udf_b_o), .err_clr_i(clr_b)
    );

    // Expected status derived purely from the model's occupancy (afull 3/4, aempty 1).
    function automatic logic [12:0] exp_a();
        int n = qa.size();
        return {n == 4, n >= 3, 3'(4 - n), n == 0, n <= 1, 3'(n), n != 0, ovf_a, udf_a};
    endfunction

    function automatic logic [12:0] exp_b();
        int n = qb.size();
        return {n == 5, n >= 4, 3'(5 - n), n == 0, n <= 1, 3'(n), vb, ovf_b, udf_b};
    endfunction

    task automatic step_a(input logic wr, input logic rd, input logic fl, input logic clr, input logic [7:0] d);
        logic full, empty;
        wr_a = wr; rd_a = rd; fl_a = fl; clr_a = clr; wd_a = d;
        @(posedge clk);
        full = qa.size() == 4;
        empty = qa.size() == 0;
        if (clr) begin ovf_a = 0; udf_a = 0; end
        if (fl) qa.delete();
        else begin
            if (wr && full && !rd) ovf_a = 1;
            if (rd && empty) udf_a = 1;
            if (rd && !empty) void'(qa.pop_front());
            if (wr && (!full || rd)) qa.push_back(d);
        end
        #1;
        wr_a = 0; rd_a = 0; fl_a = 0; clr_a = 0;
    endtask

    task automatic step_b(input logic wr, input logic rd, input logic fl, input logic clr, input logic [7:0] d);
        logic full, empty;
        wr_b = wr; rd_b = rd; fl_b = fl; clr_b = clr; wd_b = d;
        @(posedge clk);
        full = qb.size() == 5;
        empty = qb.size() == 0;
        vb = 0;
        if (clr) begin ovf_b = 0; udf_b = 0; end
        if (fl) qb.delete();
        else begin
            if (wr && full && !rd) ovf_b = 1;
            if (rd && empty) udf_b = 1;
            if (rd && !empty) begin db = qb[0]; vb = 1; void'(qb.pop_front()); end
            if (wr && (!full || rd)) qb.push_back(d);
        end
        #1;
        wr_b = 0; rd_b = 0; fl_b = 0; clr_b = 0;
    endtask

    task automatic test_reset();
        #12;
        vec++;
        if (stat_a !== 13'b0_0_100_1_1_000_0_0_0) begin miss++; $display("FAIL reset_a status got=%h exp=%h", stat_a, 13'b0_0_100_1_1_000_0_0_0); end
        vec++;
        if (stat_b !== 13'b0_0_101_1_1_000_0_0_0 || rdd_b !== 8'h00) begin miss++; $display("FAIL reset_b status got=%h/%h exp=%h/00", stat_b, rdd_b, 13'b0_0_101_1_1_000_0_0_0); end
        rst_n = 1;
        @(posedge clk); #1;
        vec++;
        if (stat_a !== exp_a()) begin miss++; $display("FAIL post_reset_a got=%h exp=%h", stat_a, exp_a()); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            step_a(1, 0, 0, 0, 8'h11 * 8'(i + 1));
            vec++;
            if (stat_a !== exp_a()) begin miss++; $display("FAIL fill status got=%h exp=%h", stat_a, exp_a()); end
        end
        vec++;
        if ({full_a, space_a, avail_a} !== 7'b1_000_100) begin miss++; $display("FAIL fill_full got=%b exp=1000100", {full_a, space_a, avail_a}); end
        for (int i = 0; i < 4; i++) begin
            e = 8'h11 * 8'(i + 1);
            vec++;
            if (rdd_a !== e) begin miss++; $display("FAIL drain_data got=%h exp=%h", rdd_a, e); end
            step_a(0, 1, 0, 0, 0);
        end
        vec++;
        if (stat_a !== exp_a() || empty_a !== 1'b1) begin miss++; $display("FAIL drain_empty got=%h exp=%h", stat_a, exp_a()); end
    endtask

    task automatic test_ovf_udf();
        for (int i = 0; i < 4; i++) step_a(1, 0, 0, 0, 8'($urandom));
        step_a(1, 0, 0, 0, 8'h55);
        vec++;
        if (stat_a !== exp_a() || ovf_a_o !== 1'b1) begin miss++; $display("FAIL ovf_set got=%h exp=%h", stat_a, exp_a()); end
        while (qa.size() != 0) begin
            vec++;
            if (rdd_a !== qa[0]) begin miss++; $display("FAIL ovf_contents got=%h exp=%h", rdd_a, qa[0]); end
            step_a(0, 1, 0, 0, 0);
        end
        step_a(0, 1, 0, 0, 0);
        vec++;
        if (stat_a !== exp_a() || udf_a_o !== 1'b1) begin miss++; $display("FAIL udf_set got=%h exp=%h", stat_a, exp_a()); end
        step_a(0, 0, 0, 1, 0);
        vec++;
        if ({ovf_a_o, udf_a_o} !== 2'b00) begin miss++; $display("FAIL err_clr got=%b exp=00", {ovf_a_o, udf_a_o}); end
        step_a(0, 1, 0, 1, 0);
        vec++;
        if (stat_a !== exp_a() || udf_a_o !== 1'b1) begin miss++; $display("FAIL set_wins got=%h exp=%h", stat_a, exp_a()); end
        step_a(0, 0, 0, 1, 0);
    endtask

    task automatic test_full_bypass();
        for (int i = 0; i < 4; i++) step_a(1, 0, 0, 0, 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (rdd_a !== qa[0]) begin miss++; $display("FAIL bypass_data got=%h exp=%h", rdd_a, qa[0]); end
            step_a(1, 1, 0, 0, 8'hAA + 8'(i));
            vec++;
            if (stat_a !== exp_a() || full_a !== 1'b1 || ovf_a_o !== 1'b0) begin miss++; $display("FAIL bypass_status got=%h exp=%h", stat_a, exp_a()); end
        end
        while (qa.size() != 0) begin
            vec++;
            if (rdd_a !== qa[0]) begin miss++; $display("FAIL bypass_drain got=%h exp=%h", rdd_a, qa[0]); end
            step_a(0, 1, 0, 0, 0);
        end
    endtask

    task automatic test_thresholds();
        logic [4:0] aemp_t = 5'b00011, afull_t = 5'b11000;
        for (int l = 0; l <= 4; l++) begin
            vec++;
            if ({aempty_a, afull_a} !== {aemp_t[l], afull_t[l]}) begin miss++; $display("FAIL thresh level=%0d got=%b exp=%b", l, {aempty_a, afull_a}, {aemp_t[l], afull_t[l]}); end
            if (l < 4) step_a(1, 0, 0, 0, 8'($urandom));
        end
    endtask

    task automatic test_flush();
        step_a(0, 1, 0, 0, 0);
        step_a(1, 0, 1, 0, 8'h99);
        vec++;
        if (stat_a !== exp_a() || stat_a !== 13'b0_0_100_1_1_000_0_0_0) begin miss++; $display("FAIL flush got=%h exp=%h", stat_a, exp_a()); end
        step_a(1, 0, 0, 0, 8'h77);
        vec++;
        if (rdd_a !== 8'h77) begin miss++; $display("FAIL flush_write got=%h exp=77", rdd_a); end
        step_a(0, 1, 0, 0, 0);
        vec++;
        if (stat_a !== exp_a()) begin miss++; $display("FAIL flush_read got=%h exp=%h", stat_a, exp_a()); end
    endtask

    task automatic test_random_a();
        logic wr, rd, fl, clr;
        for (int i = 0; i < 400; i++) begin
            wr = $urandom_range(0, 9) < 6;
            rd = $urandom_range(0, 9) < 5;
            fl = $urandom_range(0, 24) == 0;
            clr = $urandom_range(0, 15) == 0;
            dft = 4'($urandom);
            if (rd && qa.size() != 0) begin
                vec++;
                if (rdd_a !== qa[0]) begin miss++; $display("FAIL rand_a_data got=%h exp=%h", rdd_a, qa[0]); end
            end
            step_a(wr, rd, fl, clr, 8'($urandom));
            vec++;
            if (stat_a !== exp_a()) begin miss++; $display("FAIL rand_a_status got=%h exp=%h", stat_a, exp_a()); end
        end
        dft = 4'h0;
    endtask

    task automatic test_outreg();
        for (int i = 0; i < 7; i++) begin
            step_b(1, i >= 2 && i[0], 0, 0, 8'($urandom));
            vec++;
            if (stat_b !== exp_b() || rdd_b !== db) begin miss++; $display("FAIL outreg_wr got=%h/%h exp=%h/%h", stat_b, rdd_b, exp_b(), db); end
        end
        for (int i = 0; i < 6; i++) begin
            step_b(0, 1, 0, 0, 0);
            vec++;
            if (stat_b !== exp_b() || rdd_b !== db) begin miss++; $display("FAIL outreg_rd got=%h/%h exp=%h/%h", stat_b, rdd_b, exp_b(), db); end
        end
        step_b(0, 0, 0, 0, 0);
        vec++;
        if (valid_b !== 1'b0 || rdd_b !== db) begin miss++; $display("FAIL outreg_hold got=%b/%h exp=0/%h", valid_b, rdd_b, db); end
    endtask

    task automatic test_random_b();
        for (int i = 0; i < 400; i++) begin
            step_b($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 24) == 0,
                   $urandom_range(0, 15) == 0, 8'($urandom));
            vec++;
            if (stat_b !== exp_b() || rdd_b !== db) begin miss++; $display("FAIL rand_b got=%h/%h exp=%h/%h", stat_b, rdd_b, exp_b(), db); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, 8'($urandom));
        step_b(1, 0, 0, 0, 8'h3C);
        step_b(0, 1, 0, 0, 0);
        #3 rst_n = 0;
        #1;
        qa.delete(); qb.delete();
        ovf_a = 0; udf_a = 0; ovf_b = 0; udf_b = 0; vb = 0; db = 0;
        vec++;
        if (stat_a !== exp_a()) begin miss++; $display("FAIL reset_mid_a got=%h exp=%h", stat_a, exp_a()); end
        vec++;
        if (stat_b !== exp_b() || rdd_b !== 8'h00) begin miss++; $display("FAIL reset_mid_b got=%h/%h exp=%h/00", stat_b, rdd_b, exp_b()); end
        #2 rst_n = 1;
        @(posedge clk); #1;
        step_a(1, 0, 0, 0, 8'h5A);
        vec++;
        if (stat_a !== exp_a() || rdd_a !== 8'h5A) begin miss++; $display("FAIL after_reset got=%h/%h exp=%h/5a", stat_a, rdd_a, exp_a()); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_ovf_udf();
        test_full_bypass();
        test_thresholds();
        test_flush();
        test_random_a();
        test_outreg();
        test_random_b();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
